// File: rtl/serial_nibble_pkg.sv
// Shared types and line-level constants for the serial nibble receiver.
package serial_nibble_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    PARITY,
    WAIT_IDLE
  } state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  localparam int DEF_DATA_W  = 4;
  localparam int DEF_BIT_CYC = 4;

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: counts 0..tc and pulses tick in the cycle the count equals tc.
module bit_timer #(
  parameter int CW = 8
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          clr,
  input  logic [CW-1:0] tc,
  output logic          tick
);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == tc);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge Clk) begin
    if (Rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/serial_nibble_rx.sv
// Serial-to-parallel nibble receiver (start bit, LSB-first data, stop bit).
// Optional even-parity bit enabled with SERIAL_NIBBLE_RX_PARITY_EN.
//
// state     | meaning
// IDLE      | line idle, waiting for a low level
// START     | half bit time, confirm start bit is still low
// DATA      | sample one data bit per bit time into shadow
// PARITY    | sample even-parity bit (parity build only)
// STOP      | sample stop bit, commit word or flag frame error
// WAIT_IDLE | after framing error, wait for line to return high
module serial_nibble_rx
  import serial_nibble_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int BIT_CYC = DEF_BIT_CYC,
  parameter int CW      = 8
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Sin,
  output logic [DATA_W-1:0] Data,
  output logic              Valid,
  output logic              FrameErr,
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
  output logic              ParErr,
`endif
  output logic              Busy
);

  localparam int            IW       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] TC_HALF  = CW'(BIT_CYC / 2 - 1);
  localparam logic [CW-1:0] TC_FULL  = CW'(BIT_CYC - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              valid_q, valid_d;
  logic              ferr_q, ferr_d;
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
  logic              par_bad_q, par_bad_d;
  logic              perr_q, perr_d;
`endif

  logic              tmr_clr;
  logic [CW-1:0]     tmr_tc;
  logic              tick;

  // Timer is held at zero while idle so START always begins from a clean count.
  assign tmr_clr = (state_q == IDLE);

  bit_timer #(.CW(CW)) u_bit_timer (
    .Clk  (Clk),
    .Rst  (Rst),
    .clr  (tmr_clr),
    .tc   (tmr_tc),
    .tick (tick)
  );

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    idx_d    = idx_q;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;
    tmr_tc   = TC_FULL;
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (Sin == START_LVL) state_d = START;
      end
      START: begin
        tmr_tc = TC_HALF;
        if (tick) begin
          if (Sin == START_LVL) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shadow_d = (shadow_q >> 1) | (DATA_W'(Sin) << (DATA_W - 1));
          if (idx_q == LAST_IDX) begin
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          par_bad_d = (^shadow_q) ^ Sin;
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (Sin == STOP_LVL) begin
            state_d = IDLE;
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
            if (par_bad_q) begin
              perr_d = 1'b1;
            end else begin
              data_d  = shadow_q;
              valid_d = 1'b1;
            end
`else
            data_d  = shadow_q;
            valid_d = 1'b1;
`endif
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (Sin == LINE_IDLE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      data_q   <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign Data     = data_q;
  assign Valid    = valid_q;
  assign FrameErr = ferr_q;
  assign Busy     = (state_q != IDLE);
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
  assign ParErr   = perr_q;
`endif

endmodule

// File: tb/tb_serial_nibble_rx.sv
// Scoreboard bench for serial_nibble_rx: stimulus pushes expected pulses, monitor pops and checks.
// Cycle n is the clock period ending at posedge n; outputs are sampled at the negedge inside it.
module tb_serial_nibble_rx;

  localparam int BIT_CYC = 4;
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
  localparam int LAT    = 27;
  localparam bit PAR_EN = 1'b1;
`else
  localparam int LAT    = 23;
  localparam bit PAR_EN = 1'b0;
`endif
  localparam logic [2:0] K_VALID = 3'b001;
  localparam logic [2:0] K_FERR  = 3'b010;
  localparam logic [2:0] K_PERR  = 3'b100;

  typedef struct {
    logic [2:0] kind;
    logic [3:0] data;
    int         cyc;
  } exp_t;

  logic       Clk, Rst, Sin;
  logic [3:0] Data;
  logic       Valid, FrameErr, Busy, par_err;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic       rst_at_edge = 1'b1;
  logic [3:0] prev_data = 4'd0;
  logic [3:0] model_data = 4'd0;

  serial_nibble_rx #(.DATA_W(4), .BIT_CYC(BIT_CYC), .CW(8)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Sin      (Sin),
    .Data     (Data),
    .Valid    (Valid),
    .FrameErr (FrameErr),
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
    .ParErr   (par_err),
`endif
    .Busy     (Busy)
  );

`ifndef SERIAL_NIBBLE_RX_PARITY_EN
  assign par_err = 1'b0;
`endif

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= Rst;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc + 1);
    end
  endtask

  always @(negedge Clk) begin
    if (!Rst && !rst_at_edge) begin
      if (Data !== prev_data) chk("data_changes_only_with_valid", 32'(Valid), 32'd1);
      if (Valid || FrameErr || par_err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {29'd0, par_err, FrameErr, Valid}, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("pulse_kind", {29'd0, par_err, FrameErr, Valid}, {29'd0, mon_e.kind});
          chk("pulse_cycle", 32'(cyc + 1), 32'(mon_e.cyc));
          chk("pulse_data", {28'd0, Data}, {28'd0, mon_e.data});
        end
      end
    end
    prev_data <= Data;
  end

  task automatic drive(input logic b, input int n);
    repeat (n) begin
      @(negedge Clk);
      Sin = b;
    end
  endtask

  // Sends start, LSB-first data, optional parity, stop; ends in the last cycle of the stop bit.
  task automatic send_frame(input logic [3:0] d, input logic stop_b, input logic par_flip);
    logic seq[$];
    exp_t e;
    int   t0;
    seq.push_back(1'b0);
    for (int i = 0; i < 4; i++) seq.push_back(d[i]);
    if (PAR_EN) seq.push_back((^d) ^ par_flip);
    seq.push_back(stop_b);
    if (!stop_b) begin
      e.kind = K_FERR;
    end else if (par_flip && PAR_EN) begin
      e.kind = K_PERR;
    end else begin
      e.kind     = K_VALID;
      model_data = d;
    end
    e.data = model_data;
    foreach (seq[i]) begin
      @(negedge Clk);
      Sin = seq[i];
      if (i == 0) begin
        t0    = cyc + 1;
        e.cyc = t0 + LAT;
        exp_q.push_back(e);
      end
      for (int k = 1; k < BIT_CYC; k++) begin
        @(negedge Clk);
        if (i == 0 && k == 1) chk("busy_after_start", 32'(Busy), 32'd1);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst = 1'b1;
    Sin = 1'b1;
    // 1: reset state, then idle line
    repeat (2) @(negedge Clk);
    chk("rst_data", {28'd0, Data}, 32'd0);
    chk("rst_valid", 32'(Valid), 32'd0);
    chk("rst_frameerr", 32'(FrameErr), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    Rst = 1'b0;
    drive(1'b1, 20);
    chk("idle_data", {28'd0, Data}, 32'd0);
    chk("idle_valid", 32'(Valid), 32'd0);
    chk("idle_frameerr", 32'(FrameErr), 32'd0);
    chk("idle_busy", 32'(Busy), 32'd0);

    // 2: good frame 1011
    send_frame(4'b1011, 1'b1, 1'b0);
    chk("busy_low_after_stop", 32'(Busy), 32'd0);
    drive(1'b1, 4);

    // 3: one-cycle glitch rejected in START
    @(negedge Clk);
    Sin = 1'b0;
    @(negedge Clk);
    Sin = 1'b1;
    chk("glitch_busy_high", 32'(Busy), 32'd1);
    repeat (2) @(negedge Clk);
    chk("glitch_busy_drop", 32'(Busy), 32'd0);
    chk("glitch_data_kept", {28'd0, Data}, {28'd0, model_data});
    drive(1'b1, 4);

    // 4: framing error then stuck-low line
    send_frame(4'b1100, 1'b0, 1'b0);
    drive(1'b0, 30);
    chk("wait_idle_busy", 32'(Busy), 32'd1);
    chk("ferr_data_kept", {28'd0, Data}, 32'hB);
    drive(1'b1, 3);
    chk("wait_idle_exit", 32'(Busy), 32'd0);
    drive(1'b1, 4);

    // 5: back-to-back frames
    send_frame(4'b0001, 1'b1, 1'b0);
    send_frame(4'b1111, 1'b1, 1'b0);
    chk("b2b_last_data", {28'd0, Data}, 32'hF);
    drive(1'b1, 4);

    // 6: reset mid-frame aborts, then clean frame
    drive(1'b0, 4);
    drive(1'b0, 4);
    drive(1'b1, 4);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst        = 1'b0;
    Sin        = 1'b1;
    model_data = 4'd0;
    chk("abort_data_reset", {28'd0, Data}, 32'd0);
    chk("abort_busy", 32'(Busy), 32'd0);
    drive(1'b1, 4);
    send_frame(4'b0010, 1'b1, 1'b0);
    drive(1'b1, 4);
    send_frame(4'b0010, 1'b1, 1'b1);
    drive(1'b1, 10);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_nibble_rx.md
Name: serial_nibble_rx

Overview:
Serial-to-parallel receiver for the 4-bit datapath. Takes a 1-bit asynchronous-format serial line (idle high, start bit 0, DATA_W data bits LSB first, stop bit 1) and reassembles the nibble. It then presents the word to downstream registered logic with a one-cycle valid strobe. This is the receive end of the link that carries 4-bit In words between blocks.

Parameters:
DATA_W, 4, data bits per frame (>=1)
BIT_CYC, 4, Clk cycles per serial bit; even, >=2
CW, 8, width of internal bit-timer counter; must hold BIT_CYC-1

Ports:
Clk  input  1  system clock, all state updates on posedge
Rst  input  1  synchronous, active-high reset
Sin  input  1  serial line, synchronous to Clk, idles 1
Data  output  DATA_W  last correctly framed word, registered
Valid  output  1  one-cycle pulse: Data just updated
FrameErr  output  1  one-cycle pulse: stop bit sampled 0
Busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (Rst=1 at posedge): state=IDLE, Data=0, Valid=0, FrameErr=0, Busy=0, counters=0.
- Reset mid-frame aborts the frame; no Valid/FrameErr is emitted.
- States: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: at the first posedge with Sin=0 (cycle t0), go to START and clear the timer.
- START: at t0+BIT_CYC/2, re-sample Sin.
  - Sin=1: false start, return to IDLE with no pulse.
  - Sin=0: go to DATA, clear the timer and bit index.
- DATA: sample Sin every BIT_CYC cycles. Bit i (LSB first) is sampled at t0+BIT_CYC/2+(i+1)*BIT_CYC and shifted into a shadow register. After bit DATA_W-1, go to STOP.
- STOP: sample at t0+BIT_CYC/2+(DATA_W+1)*BIT_CYC.
  - Sin=1: Data<=shadow, Valid=1 for the next cycle only, go to IDLE.
  - Sin=0: FrameErr=1 for the next cycle only, Data unchanged, go to WAIT_IDLE.
- WAIT_IDLE: stay until Sin=1, then go to IDLE. This prevents a stuck-low line from retriggering.
- Latency: Valid is high in cycle t0+BIT_CYC/2+(DATA_W+1)*BIT_CYC+1. Defaults give t0+23.
- Back-to-back frames: a start bit may begin the cycle after the STOP sample. IDLE accepts it immediately, so no dead cycle is required.
- Valid and FrameErr are never high together. Data is stable except in the cycle Valid asserts.
- Busy is high from t0+1 through the STOP sample cycle, and during WAIT_IDLE.
- Timer counts 0..BIT_CYC-1, then wraps to 0. A tick fires at the wrap (START uses BIT_CYC/2-1 as its terminal count).

Optional Feature:
Macro: SERIAL_NIBBLE_RX_PARITY_EN.
- Defined:
  - Adds state PARITY between DATA and STOP, one bit time long. It samples an even-parity bit (XOR of data bits and parity bit must be 0).
  - Adds output ParErr (1 bit), a one-cycle pulse at the same time Valid would fire.
  - A parity mismatch with a good stop bit raises ParErr instead of Valid, and Data is unchanged.
  - Frame latency grows by BIT_CYC. Defaults give Valid at t0+27.
- Undefined: no PARITY state, no ParErr port, frame exactly as above.

Decomposition:
- Package serial_nibble_pkg:
  - state enum (IDLE, START, DATA, STOP, PARITY, WAIT_IDLE)
  - constants LINE_IDLE=1'b1, START_LVL=1'b0, STOP_LVL=1'b1
  - default DATA_W and BIT_CYC
- Sub-module bit_timer: counter with clear, a terminal-count input, and a single-cycle tick output. It is instantiated once and reused by START, DATA, PARITY and STOP.
- Shift register and FSM stay in the top module.

Test Plan:
1. Rst=1 for 2 cycles, Sin=1 -> Data=0000, Valid=0, FrameErr=0, Busy=0. Then Rst=0 with Sin=1 for 20 cycles -> outputs unchanged.
2. Frame for 4'b1011 (bits 1,1,0,1 LSB first), stop=1, BIT_CYC=4, start at t0 -> Valid=1 at exactly t0+23 for one cycle, Data=1011, Busy low from t0+23.
3. Sin low for only 1 cycle, then high -> START rejects at t0+2, no Valid/FrameErr, Busy drops, Data keeps its previous value.
4. Frame for 4'b1100 with stop bit 0, then Sin held 0 for 30 cycles, then 1 -> FrameErr single pulse at t0+23, Data unchanged, no new frame until Sin returns to 1.
5. Frames 4'b0001 then 4'b1111 sent back-to-back (second start bit immediately after first stop bit) -> two Valid pulses 24 cycles apart, Data=0001 then 1111.
6. Rst=1 asserted at t0+12 mid-frame, then a clean 4'b0010 frame -> no pulse for the aborted frame; Data=0010 with Valid after the clean frame. With SERIAL_NIBBLE_RX_PARITY_EN, wrong parity on 4'b0010 -> ParErr at t0+27, Data unchanged.
